// File: rtl/fre_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Holds the state encoding and the divisor clamp used on every load path.
package fre_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam int DIV_MIN = 2;

    // Divisors 0 and 1 cannot produce a waveform, so they are treated as 2.
    function automatic logic [15:0] clamp_div(input logic [15:0] n);
        return (n < 16'(DIV_MIN)) ? 16'(DIV_MIN) : n;
    endfunction

endpackage

// File: rtl/fre_div_odd_ext.sv
// Falling-edge half-cycle extension for odd divisors and the output OR.
// Kept separate so the only negedge register can be constrained on its own.
module fre_div_odd_ext (
    input  logic clk,
    input  logic rst_n,
    input  logic p_reg,
    input  logic odd,
    output logic clk_d
);

    logic n_reg;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg <= 1'b0;
        end else begin
            n_reg <= p_reg;
        end
    end

    // Both terms are registers that overlap, so the OR cannot glitch.
    assign clk_d = p_reg | (odd & n_reg);

endmodule

// File: rtl/fre_div_prog.sv
// Runtime-programmable integer clock divider with 50% duty for even and odd N.
// Divisor changes take effect only at period boundaries; start/stop never truncate a period.
module fre_div_prog
    import fre_div_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int DIV_INIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_num,
    output logic             clk_d,
    output logic             tick,
    output logic             active,
    output logic             div_upd
);

    localparam logic [CNT_W-1:0] INIT_N = CNT_W'(clamp_div(16'(DIV_INIT)));

    state_t           state;
    logic [CNT_W-1:0] act_n;
    logic [CNT_W-1:0] pend_n;
    logic             pend_v;
    logic [CNT_W-1:0] cnt;
    logic             p_reg;
    logic             upd_pend;

    logic [CNT_W-1:0] load_n;
    logic [CNT_W-1:0] half_n;
    logic [CNT_W-1:0] cnt_inc;
    logic             last;

    assign load_n  = CNT_W'(clamp_div(16'(div_num)));
    assign half_n  = act_n >> 1;
    assign cnt_inc = cnt + CNT_W'(1);
    assign last    = (cnt == (act_n - CNT_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            act_n    <= INIT_N;
            pend_n   <= INIT_N;
            pend_v   <= 1'b0;
            cnt      <= '0;
            p_reg    <= 1'b0;
            upd_pend <= 1'b0;
            tick     <= 1'b0;
            active   <= 1'b0;
            div_upd  <= 1'b0;
        end else begin
            tick    <= 1'b0;
            div_upd <= 1'b0;
            case (state)
                IDLE: begin
                    cnt    <= '0;
                    p_reg  <= 1'b0;
                    active <= 1'b0;
                    if (div_load) begin
                        act_n    <= load_n;
                        upd_pend <= 1'b1;
                    end
                    if (en) begin
                        state <= RUN;
                    end
                end
                RUN, STOP: begin
                    if (!active) begin
                        // First edge after leaving IDLE: phase 0 of the first period.
                        cnt      <= '0;
                        p_reg    <= 1'b1;
                        tick     <= 1'b1;
                        active   <= 1'b1;
                        div_upd  <= upd_pend | div_load;
                        upd_pend <= 1'b0;
                        if (div_load) begin
                            act_n <= load_n;
                        end
                        state <= en ? RUN : STOP;
                    end else if (last) begin
                        // A load in the last phase bypasses the pending slot.
                        if (div_load) begin
                            act_n <= load_n;
                        end else if (pend_v) begin
                            act_n <= pend_n;
                        end
                        pend_v <= 1'b0;
                        cnt    <= '0;
                        if (!en) begin
                            state    <= IDLE;
                            p_reg    <= 1'b0;
                            active   <= 1'b0;
                            upd_pend <= div_load | pend_v;
                        end else begin
                            state   <= RUN;
                            p_reg   <= 1'b1;
                            tick    <= 1'b1;
                            div_upd <= div_load | pend_v;
                        end
                    end else begin
                        cnt   <= cnt_inc;
                        p_reg <= (cnt_inc < half_n);
                        if (div_load) begin
                            pend_n <= load_n;
                            pend_v <= 1'b1;
                        end
                        if (state == RUN && !en) begin
                            state <= STOP;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fre_div_odd_ext u_odd_ext (
        .clk   (clk),
        .rst_n (rst_n),
        .p_reg (p_reg),
        .odd   (act_n[0]),
        .clk_d (clk_d)
    );

endmodule

// File: tb/tb_fre_div_prog.sv
// Scoreboard bench for fre_div_prog: stimulus queues expected periods, a monitor
// measures each output period in half-cycles and checks length, high time and div_upd.
module tb_fre_div_prog;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             div_load = 1'b0;
    logic [CNT_W-1:0] div_num = '0;
    logic             clk_d;
    logic             tick;
    logic             active;
    logic             div_upd;

    always #5 clk = ~clk;

    fre_div_prog #(.CNT_W(CNT_W), .DIV_INIT(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_load (div_load),
        .div_num  (div_num),
        .clk_d    (clk_d),
        .tick     (tick),
        .active   (active),
        .div_upd  (div_upd)
    );

    typedef struct {
        int n;
        int upd;
    } exp_t;

    typedef struct {
        int n;      // expected length of this period
        int upd;    // expected div_upd at its start
        int lpa;    // phase of first load (-1 none)
        int lva;
        int lpb;    // phase of second load (-1 none)
        int lvb;
        int off_p;  // phase at which en drops (-1 none)
        int on_p;   // phase at which en rises (-1 none)
    } step_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    step_t steps [15] = '{
        '{2,   0, -1,   0, -1, 0, -1, -1},
        '{2,   0,  0,   5, -1, 0, -1, -1},
        '{5,   1, -1,   0, -1, 0, -1, -1},
        '{5,   0,  2,   3, -1, 0, -1, -1},
        '{3,   1,  1, 255, -1, 0, -1, -1},
        '{255, 1, 100,  4, -1, 0, -1, -1},
        '{4,   1, -1,   0, -1, 0, -1, -1},
        '{4,   0,  1,   7, -1, 0, -1, -1},
        '{7,   1,  1,   6,  3, 9, -1, -1},
        '{9,   1,  8,   4, -1, 0, -1, -1},
        '{4,   1,  3,   0, -1, 0, -1, -1},
        '{2,   1,  0,   1, -1, 0, -1, -1},
        '{2,   1,  1,   6, -1, 0, -1, -1},
        '{6,   1, -1,   0, -1, 0,  1,  4},
        '{6,   0, -1,   0, -1, 0,  1, -1}
    };

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_clk_d"},   int'(clk_d),   0);
        check({tag, "_tick"},    int'(tick),    0);
        check({tag, "_active"},  int'(active),  0);
        check({tag, "_div_upd"}, int'(div_upd), 0);
    endtask

    task automatic wait_tick(input string name);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!tick && k < 20);
        if (!tick) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: tick not seen within %0d cycles", name, k);
        end
    endtask

    // Monitor: half-cycle sampling one time unit after each clock edge.
    bit   in_p = 0;
    int   len = 0;
    int   hi = 0;
    int   upd0 = 0;
    int   per_idx = 0;
    exp_t e;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                in_p = 0;
            end else begin
                if (in_p && (tick || !active)) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_period: got len %0d halves, expected no period", len);
                    end else begin
                        e = exp_q.pop_front();
                        per_idx++;
                        $display("period %0d: len=%0d halves high=%0d upd=%0d (expect N=%0d upd=%0d)",
                                 per_idx, len, hi, upd0, e.n, e.upd);
                        check("period_len", len, 2 * e.n);
                        check("high_halves", hi, e.n);
                        check("div_upd", upd0, e.upd);
                    end
                    if (!active) check("clk_d_after_stop", int'(clk_d), 0);
                    in_p = 0;
                end
                if (active && tick) begin
                    in_p = 1;
                    len  = 0;
                    hi   = 0;
                    upd0 = int'(div_upd);
                    check("clk_d_at_tick", int'(clk_d), 1);
                end
                if (in_p) begin
                    len++;
                    hi += int'(clk_d);
                end
            end
            @(negedge clk);
            #1;
            if (!rst_n) begin
                in_p = 0;
            end else if (in_p) begin
                len++;
                hi += int'(clk_d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("active_at_E0", int'(active), 0);
        @(posedge clk);
        #1;
        check("active_at_E1", int'(active), 1);
        check("tick_at_E1", int'(tick), 1);

        for (int s = 0; s < 15; s++) begin
            exp_q.push_back('{steps[s].n, steps[s].upd});
            for (int ph = 0; ph < steps[s].n; ph++) begin
                @(negedge clk);
                div_load = (ph == steps[s].lpa) || (ph == steps[s].lpb);
                if (ph == steps[s].lpa)      div_num = CNT_W'(steps[s].lva);
                else if (ph == steps[s].lpb) div_num = CNT_W'(steps[s].lvb);
                else                         div_num = '0;
                if (ph == steps[s].off_p) en = 1'b0;
                if (ph == steps[s].on_p)  en = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        check("active_after_stop", int'(active), 0);

        // Load while idle, restart, then reset asynchronously in phase 3 of N=5.
        @(negedge clk);
        div_load = 1'b1;
        div_num  = CNT_W'(5);
        @(negedge clk);
        div_load = 1'b0;
        div_num  = '0;
        en       = 1'b1;
        exp_q.push_back('{5, 1});
        wait_tick("idle_load_start");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        exp_q.delete();

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back('{2, 0});
        wait_tick("restart_p1");
        wait_tick("restart_p2");
        wait_tick("restart_p3");
        @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 20 && active; k++) begin
            @(posedge clk);
            #1;
        end
        check("final_active", int'(active), 0);
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fre_div_prog.md
# fre_div_prog

Runtime-programmable integer clock divider, the parametrised successor to the fixed-ratio divider. It divides `clk` by any integer N from 2 to 2^CNT_W−1 with 50 % duty for both even and odd N. N can be changed at run time without glitches, and the output can be started and stopped cleanly. It sits next to the clock generation logic and drives slow peripheral clocks and baud/sample strobes.

## Interface
- `CNT_W`, default 8: width of the divisor and the internal counter; legal range 2..16.
- `DIV_INIT`, default 2: divisor active after reset; clamped like `div_num`.
- `clk` in 1: source clock; all logic uses the rising edge except the odd-duty half-cycle register.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: run request.
- `div_load` in 1: one-cycle strobe that captures `div_num`.
- `div_num` in CNT_W: requested divisor N; values 0 and 1 are clamped to 2.
- `clk_d` out 1: divided clock.
- `tick` out 1: one `clk`-cycle pulse in the first cycle of every output period (clk_d high phase start).
- `active` out 1: high while periods are being generated.
- `div_upd` out 1: one-cycle pulse in the first cycle of the first period that uses a newly loaded divisor.

## Operation
- **Registers**
  - `act_n`: divisor in use.
  - `pend_n` / `pend_v`: pending divisor and its valid flag.
  - `cnt` (CNT_W bits): phase counter.
  - `p_reg`: rising-edge phase register.
  - `n_reg`: falling-edge copy of `p_reg`.
- **Counter:** while running, `cnt` counts 0..act_n−1 and wraps to 0. Phase 0 is the first cycle of a period.
- **Waveform:** let H = floor(act_n/2).
  - `p_reg` is high during phases 0..H−1.
  - `clk_d` = `p_reg` | (`act_n[0]` & `n_reg`). For odd N this stretches the high time by half a cycle.
  - Result: high H cycles, low H cycles for even N; high H+0.5, low H+0.5 for odd N.
  - `clk_d` is an OR of overlapping registers only; there is no combinational path from `clk` to `clk_d`.
- **Divisor loading:**
  - `div_load` writes clamp(`div_num`) to `pend_n` and sets `pend_v`. If several loads arrive in one period, the last one wins.
  - In the last phase of a period (cnt == act_n−1) with `pend_v` set, `act_n` takes `pend_n` and `pend_v` clears.
  - A `div_load` in that same last-phase cycle takes effect at this boundary; it bypasses `pend_n`.
  - `div_upd` pulses in phase 0 of the next period.
- **State machine:**
  - IDLE: `cnt`=0, `clk_d`=0, `active`=0. Go to RUN when `en`=1.
  - RUN: go to STOP when `en`=0.
  - STOP: finish the current period. At the boundary, go to IDLE; if `en` has returned to 1, continue in RUN with no gap.
  - No truncated period is ever produced.
- While IDLE, `div_load` applies to `act_n` immediately; `div_upd` pulses on the next period start.

## Timing
- **Reset:** all outputs 0; `act_n`=clamp(DIV_INIT); `pend_v`=0; state IDLE.
- **Start:** `en` sampled high on rising edge E0 → state RUN; phase 0 begins at E1.
  - `clk_d` rises and `tick`=1 after E1 (registered).
  - `active`=1 from E1.
- **Steady state:** `clk_d` rising edges are exactly act_n `clk` cycles apart. `tick` is coincident with each `clk_d` rise.
- **Divisor change:** new period length applies starting at the period following the boundary where it was applied. Latency from `div_load` is at most one old period + 1 cycle.
- **Stop:** `active` drops in the cycle after the final phase. `clk_d` is low from then on; for odd N the falling-edge extension also completes first.
- **Reset mid-period:** immediate asynchronous return to reset values; no partial-period guarantee.

## Structure
- **Package `fre_div_pkg`**
  - state enum: IDLE, RUN, STOP.
  - `DIV_MIN`=2.
  - function `clamp_div(n)`: returns 2 for n<2, otherwise n.
- **Sub-module `fre_div_odd_ext`:** the falling-edge `n_reg` register plus the output OR/select. It isolates the only negedge logic for timing constraints.
- All remaining logic (state machine, counter, load path) lives in the top level.

## Test plan
- **Reset/start, DIV_INIT=2:** release reset, `en`=1 → `clk_d` toggles every cycle, `tick` every 2 cycles, `active`=1 one cycle after `en` is sampled.
- **Odd duty, load N=5:** high time 2.5 cycles, low 2.5 cycles, rising edges 5 cycles apart; repeat for N=3 and N=2^CNT_W−1.
- **Runtime change:**
  - While N=4, `div_load` N=7 mid-period → current period stays 4 cycles, next is 7, `div_upd` pulses at its start.
  - Two loads (6 then 9) in one period → only 9 is applied.
  - Load in the last phase → applied at that boundary.
- **Clamp:** `div_num`=0 and 1 → behaves as N=2; no stuck output.
- **Stop/restart:**
  - Drop `en` at phase 1 of N=6 → period completes with full 3/3 waveform, then `clk_d`=0, `active`=0.
  - Re-raise `en` before the boundary → back-to-back periods with no gap.
- **Asynchronous reset mid-period (N=5, phase 3):** all outputs 0 immediately; restart produces a correct first period with N=DIV_INIT.
